// File: rtl/ysyx_220053_idex_buffer.sv
// ID/EX skid buffer: holds up to two decoded instructions ahead of the ALU
// and presents the head entry's muxed operands to the execute stage.
module ysyx_220053_idex_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_pc,
  input  logic [63:0] in_src1,
  input  logic [63:0] in_src2,
  input  logic [63:0] in_imm,
  input  logic [3:0]  in_alu_op,
  input  logic        in_sel_a,
  input  logic        in_sel_b,
  input  logic [4:0]  in_rd,
  input  logic        in_wen,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] inputa,
  output logic [63:0] inputb,
  output logic [3:0]  ALUOp,
  output logic [63:0] out_pc,
  output logic [4:0]  out_rd,
  output logic        out_wen
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned OPW  = 4;
  localparam int unsigned RW   = 5;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] imm;
    logic [OPW-1:0]  alu_op;
    logic            sel_a;
    logic            sel_b;
    logic [RW-1:0]   rd;
    logic            wen;
  } payload_t;

  logic [1:0] state_q, state_d;
  payload_t   main_q, main_d;
  payload_t   skid_q, skid_d;
  payload_t   in_payload;
  logic       in_ready_q, in_ready_d;
  logic       in_fire, out_fire;

  always_comb begin
    in_payload        = '0;
    in_payload.pc     = in_pc;
    in_payload.src1   = in_src1;
    in_payload.src2   = in_src2;
    in_payload.imm    = in_imm;
    in_payload.alu_op = in_alu_op;
    in_payload.sel_a  = in_sel_a;
    in_payload.sel_b  = in_sel_b;
    in_payload.rd     = in_rd;
    in_payload.wen    = in_wen;
  end

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid & out_ready;

  // Next-state and payload steering; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          main_d  = in_payload;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_fire && out_fire) begin
          main_d = in_payload;
        end else if (in_fire) begin
          skid_d  = in_payload;
          state_d = ST_FULL;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
    end
    // Registered ready mirrors the upcoming state so FULL never accepts.
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign inputa    = main_q.sel_a ? main_q.pc : main_q.src1;
  assign inputb    = main_q.sel_b ? main_q.imm : main_q.src2;
  assign ALUOp     = main_q.alu_op;
  assign out_pc    = main_q.pc;
  assign out_rd    = main_q.rd;
  assign out_wen   = main_q.wen;

endmodule

// File: tb/tb_ysyx_220053_idex_buffer.sv
// Bench for the ID/EX skid buffer: a queue of expected entries is filled as
// beats are accepted and checked against the head outputs.
module tb_ysyx_220053_idex_buffer;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] src1;
    logic [63:0] src2;
    logic [63:0] imm;
    logic [3:0]  op;
    logic        sa;
    logic        sb;
    logic [4:0]  rd;
    logic        wen;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_pc = '0, in_src1 = '0, in_src2 = '0, in_imm = '0;
  logic [3:0]  in_alu_op = '0;
  logic        in_sel_a = 1'b0, in_sel_b = 1'b0;
  logic [4:0]  in_rd = '0;
  logic        in_wen = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] inputa, inputb, out_pc;
  logic [3:0]  ALUOp;
  logic [4:0]  out_rd;
  logic        out_wen;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t sbq[$];

  ysyx_220053_idex_buffer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_src1(in_src1), .in_src2(in_src2), .in_imm(in_imm),
    .in_alu_op(in_alu_op), .in_sel_a(in_sel_a), .in_sel_b(in_sel_b),
    .in_rd(in_rd), .in_wen(in_wen),
    .out_valid(out_valid), .out_ready(out_ready),
    .inputa(inputa), .inputb(inputb), .ALUOp(ALUOp),
    .out_pc(out_pc), .out_rd(out_rd), .out_wen(out_wen)
  );

  always #5 clk = ~clk;

  // Expected head outputs {inputa, inputb, ALUOp, out_pc, out_rd, out_wen}.
  function automatic logic [201:0] head_vec(input beat_t b);
    head_vec = {(b.sa ? b.pc : b.src1), (b.sb ? b.imm : b.src2), b.op, b.pc, b.rd, b.wen};
  endfunction

  function automatic beat_t mk(input logic [63:0] pc, input logic [63:0] s1,
                               input logic [63:0] s2, input logic [63:0] imm,
                               input logic [3:0] op, input logic sa, input logic sb,
                               input logic [4:0] rd, input logic wen);
    mk = '{pc: pc, src1: s1, src2: s2, imm: imm, op: op, sa: sa, sb: sb, rd: rd, wen: wen};
  endfunction

  task automatic drive(input logic v, input beat_t b);
    in_valid  = v;
    in_pc     = b.pc;
    in_src1   = b.src1;
    in_src2   = b.src2;
    in_imm    = b.imm;
    in_alu_op = b.op;
    in_sel_a  = b.sa;
    in_sel_b  = b.sb;
    in_rd     = b.rd;
    in_wen    = b.wen;
  endtask

  // Advance one clock and update the reference occupancy from the bench's own view.
  task automatic tick();
    bit    acc, pop;
    beat_t b;
    acc = in_valid && (sbq.size() < 2);
    pop = out_ready && (sbq.size() > 0);
    b   = mk(in_pc, in_src1, in_src2, in_imm, in_alu_op, in_sel_a, in_sel_b, in_rd, in_wen);
    @(posedge clk);
    if (rst || flush) begin
      sbq.delete();
    end else begin
      if (pop) void'(sbq.pop_front());
      if (acc) sbq.push_back(b);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, mk(64'h1234, 64'h55, 64'h66, 64'h77, 4'h3, 1'b0, 1'b0, 5'd9, 1'b1));
    out_ready = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_handshake: got valid/ready=%b%b want 01", out_valid, in_ready);
    end
    n_checks++;
    if ({inputa, inputb, ALUOp, out_pc, out_rd, out_wen} !== 202'd0) begin
      n_fail++;
      $display("FAIL reset_payload: got a=%h b=%h op=%h pc=%h rd=%h wen=%b want all zero",
               inputa, inputb, ALUOp, out_pc, out_rd, out_wen);
    end
    rst = 1'b0;
    drive(1'b0, '0);
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_nocapture: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, mk(64'(32'h1000 + 4 * i), 64'(i), 64'(10 * i), 64'd0, 4'd0, 1'b0, 1'b0, 5'(i), 1'b1));
      tick();
      n_checks++;
      if ({out_valid, in_ready} !== 2'b11) begin
        n_fail++;
        $display("FAIL stream_hs[%0d]: got valid/ready=%b%b want 11", i, out_valid, in_ready);
      end
      n_checks++;
      if (sbq.size() == 0 || {inputa, inputb, ALUOp, out_pc, out_rd, out_wen} !== head_vec(sbq[0])) begin
        n_fail++;
        $display("FAIL stream_head[%0d]: got a=%0d b=%0d want a=%0d", i, inputa, inputb, i);
      end
    end
    drive(1'b0, '0);
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_skid();
    out_ready = 1'b0;
    drive(1'b1, mk(64'h2000, 64'd5, 64'd50, 64'd0, 4'd1, 1'b0, 1'b0, 5'd1, 1'b1));
    tick();
    n_checks++;
    if ({inputa, in_ready} !== {64'd5, 1'b1}) begin
      n_fail++;
      $display("FAIL skid_a: got inputa=%0d in_ready=%b want 5/1", inputa, in_ready);
    end
    drive(1'b1, mk(64'h2004, 64'd6, 64'd60, 64'd0, 4'd2, 1'b0, 1'b0, 5'd2, 1'b0));
    tick();
    n_checks++;
    if ({inputa, in_ready} !== {64'd5, 1'b0}) begin
      n_fail++;
      $display("FAIL skid_full: got inputa=%0d in_ready=%b want 5/0", inputa, in_ready);
    end
    // A beat offered while full must be ignored.
    drive(1'b1, mk(64'h2008, 64'd7, 64'd70, 64'd0, 4'd3, 1'b0, 1'b0, 5'd3, 1'b1));
    tick();
    n_checks++;
    if ({out_valid, inputa, in_ready} !== {1'b1, 64'd5, 1'b0}) begin
      n_fail++;
      $display("FAIL skid_hold: got valid=%b inputa=%0d in_ready=%b want 1/5/0", out_valid, inputa, in_ready);
    end
    drive(1'b0, '0);
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (sbq.size() != 1 || {inputa, in_ready} !== {64'd6, 1'b1} ||
        {inputa, inputb, ALUOp, out_pc, out_rd, out_wen} !== head_vec(sbq[0])) begin
      n_fail++;
      $display("FAIL skid_b: got inputa=%0d in_ready=%b want 6/1", inputa, in_ready);
    end
    tick();
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL skid_drain: got valid/ready=%b%b want 01", out_valid, in_ready);
    end
  endtask

  task automatic test_mux();
    out_ready = 1'b0;
    drive(1'b1, mk(64'h8000_0000, 64'h1111, 64'h2222, 64'hFFFF_FFFF_FFFF_FFF0, 4'b1111, 1'b1, 1'b1, 5'd31, 1'b1));
    tick();
    drive(1'b0, '0);
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if ({out_valid, inputa, inputb, ALUOp, out_rd, out_wen} !==
          {1'b1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFF0, 4'b1111, 5'd31, 1'b1}) begin
        n_fail++;
        $display("FAIL mux[%0d]: got a=%h b=%h op=%h rd=%0d want a=80000000 b=fffffffffffffff0 op=f rd=31",
                 c, inputa, inputb, ALUOp, out_rd);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, mk(64'h3000, 64'd21, 64'd0, 64'd0, 4'd4, 1'b0, 1'b0, 5'd4, 1'b1));
    tick();
    drive(1'b1, mk(64'h3004, 64'd22, 64'd0, 64'd0, 4'd5, 1'b0, 1'b0, 5'd5, 1'b1));
    tick();
    flush = 1'b1;
    drive(1'b1, mk(64'h3008, 64'd99, 64'd0, 64'd0, 4'd6, 1'b0, 1'b0, 5'd6, 1'b1));
    tick();
    flush = 1'b0;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL flush_full: got valid/ready=%b%b want 01", out_valid, in_ready);
    end
    drive(1'b0, '0);
    out_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_dropped: got out_valid=%b inputa=%0d want 0", out_valid, inputa);
    end
    // Reset mid-stall also empties and zeroes the payload.
    out_ready = 1'b0;
    drive(1'b1, mk(64'h4000, 64'd31, 64'd32, 64'd0, 4'd7, 1'b0, 1'b0, 5'd7, 1'b1));
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, '0);
    n_checks++;
    if ({out_valid, in_ready, inputa, out_rd} !== {1'b0, 1'b1, 64'd0, 5'd0}) begin
      n_fail++;
      $display("FAIL reset_stall: got valid=%b ready=%b inputa=%0d rd=%0d want 0/1/0/0",
               out_valid, in_ready, inputa, out_rd);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(1'b1, mk(64'h5000, 64'd100, 64'd200, 64'd0, 4'd8, 1'b0, 1'b0, 5'd10, 1'b1));
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk(64'(32'h5004 + 4 * i), 64'(101 + i), 64'(201 + i), 64'(i), 4'(9 + i), 1'b0, 1'(i & 1), 5'(11 + i), 1'(i & 1)));
      tick();
      n_checks++;
      if ({out_valid, in_ready} !== 2'b11 || sbq.size() != 1 ||
          {inputa, inputb, ALUOp, out_pc, out_rd, out_wen} !== head_vec(sbq[0])) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got valid=%b ready=%b a=%0d b=%0d want 1/1 a=%0d", i, out_valid, in_ready,
                 inputa, inputb, 101 + i);
      end
    end
    drive(1'b0, '0);
    tick();
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_drain: got valid/ready=%b%b want 01", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_skid();
    test_mux();
    test_flush();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
